// File: rtl/dispensador_bebidas.sv
// Actuator sequencer for the coffee-machine command word: latches a command and
// drives cup, water, powder motor and coin hoppers for fixed cycle counts.
module dispensador_bebidas #(
  parameter int unsigned T_VASO   = 4,
  parameter int unsigned T_AGUA   = 16,
  parameter int unsigned T_POLVO  = 8,
  parameter int unsigned T_MONEDA = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] cmd,
  input  logic       paro,
  output logic       ocupado,
  output logic       listo,
  output logic       err,
  output logic       vaso,
  output logic       agua,
  output logic       motor_cafe,
  output logic       motor_te,
  output logic       dev_moneda,
  output logic       dev_cinco
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_VASO,
    S_AGUA,
    S_POLVO,
    S_DEVUELVE,
    S_FIN
  } state_t;

  typedef enum logic [1:0] {
    R_NONE,
    R_FULL,
    R_CINCO
  } refund_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               es_cafe, es_cafe_n;
  refund_t            refund, refund_n;
  logic               err_n;

  // State, counter and latched command fields
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      es_cafe <= 1'b0;
      refund  <= R_NONE;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      es_cafe <= es_cafe_n;
      refund  <= refund_n;
    end
  end

  // Next-state logic; paro outranks both new commands and counter expiry
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    es_cafe_n = es_cafe;
    refund_n  = refund;
    err_n     = 1'b0;

    if (state != S_IDLE && paro) begin
      state_n = S_IDLE;
      cnt_n   = '0;
      err_n   = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (!paro) begin
            case (cmd)
              3'b111: begin
                es_cafe_n = 1'b1;
                refund_n  = R_NONE;
                cnt_n     = CNT_W'(T_VASO - 1);
                state_n   = S_VASO;
              end
              3'b110: begin
                es_cafe_n = 1'b0;
                refund_n  = R_NONE;
                cnt_n     = CNT_W'(T_VASO - 1);
                state_n   = S_VASO;
              end
              3'b101: begin
                es_cafe_n = 1'b0;
                refund_n  = R_CINCO;
                cnt_n     = CNT_W'(T_VASO - 1);
                state_n   = S_VASO;
              end
              3'b100: begin
                refund_n = R_FULL;
                cnt_n    = CNT_W'(T_MONEDA - 1);
                state_n  = S_DEVUELVE;
              end
              3'b000: ;
              default: err_n = 1'b1;
            endcase
          end
        end
        S_VASO: begin
          if (cnt == '0) begin
            cnt_n   = CNT_W'(T_AGUA - 1);
            state_n = S_AGUA;
          end else begin
            cnt_n = cnt - CNT_W'(1);
          end
        end
        S_AGUA: begin
          if (cnt == '0) begin
            cnt_n   = CNT_W'(T_POLVO - 1);
            state_n = S_POLVO;
          end else begin
            cnt_n = cnt - CNT_W'(1);
          end
        end
        S_POLVO: begin
          if (cnt == '0) begin
            if (refund == R_CINCO) begin
              cnt_n   = CNT_W'(T_MONEDA - 1);
              state_n = S_DEVUELVE;
            end else begin
              state_n = S_FIN;
            end
          end else begin
            cnt_n = cnt - CNT_W'(1);
          end
        end
        S_DEVUELVE: begin
          if (cnt == '0) begin
            state_n = S_FIN;
          end else begin
            cnt_n = cnt - CNT_W'(1);
          end
        end
        S_FIN:   state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase

      // Commands arriving while busy are dropped and flagged
      if (state != S_IDLE && cmd != 3'b000) begin
        err_n = 1'b1;
      end
    end
  end

  // Outputs registered, decoded from the next state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ocupado    <= 1'b0;
      listo      <= 1'b0;
      err        <= 1'b0;
      vaso       <= 1'b0;
      agua       <= 1'b0;
      motor_cafe <= 1'b0;
      motor_te   <= 1'b0;
      dev_moneda <= 1'b0;
      dev_cinco  <= 1'b0;
    end else begin
      ocupado    <= (state_n != S_IDLE);
      listo      <= (state_n == S_FIN);
      err        <= err_n;
      vaso       <= (state_n == S_VASO);
      agua       <= (state_n == S_AGUA);
      motor_cafe <= (state_n == S_POLVO) && es_cafe_n;
      motor_te   <= (state_n == S_POLVO) && !es_cafe_n;
      dev_moneda <= (state_n == S_DEVUELVE) && (refund_n == R_FULL);
      dev_cinco  <= (state_n == S_DEVUELVE) && (refund_n == R_CINCO);
    end
  end

endmodule

// File: tb/tb_dispensador_bebidas.sv
// Bench for dispensador_bebidas: a queue-of-output-vectors model checked every
// cycle, plus literal per-signal cycle counts for each directed scenario.
module tb_dispensador_bebidas;

  localparam int unsigned T_VASO   = 4;
  localparam int unsigned T_AGUA   = 16;
  localparam int unsigned T_POLVO  = 8;
  localparam int unsigned T_MONEDA = 2;

  // Vector layout: {ocupado, listo, err, vaso, agua, cafe, te, moneda, cinco}
  localparam logic [8:0] B_OCU   = 9'h100;
  localparam logic [8:0] B_LISTO = 9'h080;
  localparam logic [8:0] B_ERR   = 9'h040;
  localparam logic [8:0] B_VASO  = 9'h020;
  localparam logic [8:0] B_AGUA  = 9'h010;
  localparam logic [8:0] B_CAFE  = 9'h008;
  localparam logic [8:0] B_TE    = 9'h004;
  localparam logic [8:0] B_MON   = 9'h002;
  localparam logic [8:0] B_CINCO = 9'h001;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] cmd;
  logic       paro;
  logic ocupado, listo, err, vaso, agua, motor_cafe, motor_te, dev_moneda, dev_cinco;
  logic [8:0] dut_vec;

  int total = 0;
  int bad   = 0;
  int n_ocu, n_listo, n_err, n_vaso, n_agua, n_cafe, n_te, n_mon, n_cinco;

  logic [8:0] cur = '0;
  logic [8:0] q[$];

  dispensador_bebidas #(
    .T_VASO(T_VASO), .T_AGUA(T_AGUA), .T_POLVO(T_POLVO), .T_MONEDA(T_MONEDA)
  ) dut (
    .clk(clk), .rst(rst), .cmd(cmd), .paro(paro),
    .ocupado(ocupado), .listo(listo), .err(err),
    .vaso(vaso), .agua(agua), .motor_cafe(motor_cafe), .motor_te(motor_te),
    .dev_moneda(dev_moneda), .dev_cinco(dev_cinco)
  );

  assign dut_vec = {ocupado, listo, err, vaso, agua, motor_cafe, motor_te, dev_moneda, dev_cinco};

  always #5 clk = ~clk;

  // Expected per-cycle output sequence for an accepted command
  function automatic void plan(input bit drink, input bit cafe, input bit cinco, input bit full);
    if (drink) begin
      for (int i = 0; i < int'(T_VASO); i++)  q.push_back(B_OCU | B_VASO);
      for (int i = 0; i < int'(T_AGUA); i++)  q.push_back(B_OCU | B_AGUA);
      for (int i = 0; i < int'(T_POLVO); i++) q.push_back(B_OCU | (cafe ? B_CAFE : B_TE));
    end
    if (cinco || full)
      for (int i = 0; i < int'(T_MONEDA); i++) q.push_back(B_OCU | (cinco ? B_CINCO : B_MON));
    q.push_back(B_OCU | B_LISTO);
  endfunction

  // Reference model: what the outputs must show after each edge
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur = '0;
      q.delete();
    end else if (cur[8]) begin
      if (paro) begin
        q.delete();
        cur = B_ERR;
      end else begin
        cur = '0;
        if (q.size() > 0) cur = q.pop_front();
        if (cmd != 3'b000) cur = cur | B_ERR;
      end
    end else begin
      cur = '0;
      if (!paro) begin
        case (cmd)
          3'b111: plan(1'b1, 1'b1, 1'b0, 1'b0);
          3'b110: plan(1'b1, 1'b0, 1'b0, 1'b0);
          3'b101: plan(1'b1, 1'b0, 1'b1, 1'b0);
          3'b100: plan(1'b0, 1'b0, 1'b0, 1'b1);
          3'b000: ;
          default: cur = B_ERR;
        endcase
        if (q.size() > 0) cur = q.pop_front();
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    n_ocu = 0; n_listo = 0; n_err = 0; n_vaso = 0; n_agua = 0;
    n_cafe = 0; n_te = 0; n_mon = 0; n_cinco = 0;
  endtask

  // One cycle: compare against the model on the falling edge, then tally
  task automatic tick();
    @(negedge clk);
    if (rst) begin
      total++;
      if (dut_vec !== cur) begin
        bad++;
        $display("FAIL cycle_vec @%0t: got %b expected %b", $time, dut_vec, cur);
      end
    end
    n_ocu += int'(ocupado);   n_listo += int'(listo); n_err += int'(err);
    n_vaso += int'(vaso);     n_agua += int'(agua);   n_cafe += int'(motor_cafe);
    n_te += int'(motor_te);   n_mon += int'(dev_moneda); n_cinco += int'(dev_cinco);
  endtask

  task automatic issue(input logic [2:0] c, input int n);
    clear_counts();
    cmd = c;
    tick();
    cmd = 3'b000;
    repeat (n) tick();
  endtask

  initial begin
    rst = 1'b0; cmd = 3'b000; paro = 1'b0;
    tick(); tick();
    check("reset_outputs", int'(dut_vec), 0);
    rst = 1'b1;
    tick(); tick();

    // Coffee
    issue(3'b111, 34);
    check("cafe_vaso", n_vaso, 4);
    check("cafe_agua", n_agua, 16);
    check("cafe_motor", n_cafe, 8);
    check("cafe_te_off", n_te, 0);
    check("cafe_listo", n_listo, 1);
    check("cafe_ocupado", n_ocu, 29);
    check("cafe_dev_off", n_mon + n_cinco, 0);

    // Tea with 5 change
    issue(3'b101, 36);
    check("te5_vaso", n_vaso, 4);
    check("te5_motor", n_te, 8);
    check("te5_cinco", n_cinco, 2);
    check("te5_moneda_off", n_mon, 0);
    check("te5_ocupado", n_ocu, 31);
    check("te5_listo", n_listo, 1);

    // Coin return only
    issue(3'b100, 5);
    check("coin_moneda", n_mon, 2);
    check("coin_listo", n_listo, 1);
    check("coin_ocupado", n_ocu, 3);
    check("coin_actuators_off", n_vaso + n_agua + n_cafe + n_te, 0);

    // Tea, with a coffee command dropped during the water phase
    clear_counts();
    cmd = 3'b110; tick(); cmd = 3'b000;
    repeat (8) tick();
    cmd = 3'b111; tick(); cmd = 3'b000;
    repeat (30) tick();
    check("drop_err", n_err, 1);
    check("drop_no_cafe", n_cafe, 0);
    check("drop_te", n_te, 8);
    check("drop_ocupado", n_ocu, 29);
    check("drop_listo", n_listo, 1);

    // Invalid command in idle
    issue(3'b010, 2);
    check("invalid_err", n_err, 1);
    check("invalid_ocupado", n_ocu, 0);

    // paro in idle swallows a command silently
    clear_counts();
    paro = 1'b1; cmd = 3'b111; tick();
    paro = 1'b0; cmd = 3'b000;
    repeat (2) tick();
    check("paro_idle_err", n_err, 0);
    check("paro_idle_ocupado", n_ocu, 0);

    // Abort on the 5th water cycle
    clear_counts();
    cmd = 3'b111; tick(); cmd = 3'b000;
    repeat (8) tick();
    check("abort_agua_cycles", n_agua, 5);
    paro = 1'b1; tick(); paro = 1'b0;
    check("abort_vec", int'(dut_vec), int'(B_ERR));
    repeat (4) tick();
    check("abort_listo", n_listo, 0);
    check("abort_err", n_err, 1);
    issue(3'b110, 34);
    check("after_abort_te", n_te, 8);
    check("after_abort_ocupado", n_ocu, 29);

    // Asynchronous reset during the coffee motor
    clear_counts();
    cmd = 3'b111; tick(); cmd = 3'b000;
    repeat (23) tick();
    check("pre_reset_cafe", int'(motor_cafe), 1);
    #2 rst = 1'b0;
    #1 check("async_reset_vec", int'(dut_vec), 0);
    tick();
    #2 rst = 1'b1;
    clear_counts();
    repeat (5) tick();
    check("post_reset_idle", n_ocu + n_err + n_listo, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dispensador_bebidas.md
Name: dispensador_bebidas

Overview:
- Actuator-side executor for the 3-bit command word produced by the coffee-machine control FSM. Commands: 100 return coin, 111 serve coffee, 101 serve tea + return 5, 110 serve tea.
- Latches a command, runs a timed actuator sequence (cup drop, water valve, powder motor, coin hopper) and reports busy/done/error status back to the system.
- Sits between the control FSM output and the physical valves/motors.

Parameters:
- T_VASO, 4, cycles the cup-drop solenoid is held.
- T_AGUA, 16, cycles the water valve is held open.
- T_POLVO, 8, cycles the coffee/tea powder motor runs.
- T_MONEDA, 2, cycles a coin-hopper output is held.
- All T_*: legal range 1..255. The internal down-counter is 8 bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- cmd  input  3  command word from the control FSM. Valid whenever nonzero; may be held for only one cycle.
- paro  input  1  synchronous emergency stop, active-high.
- ocupado  output  1  a sequence is in progress.
- listo  output  1  one-cycle pulse when a sequence completes normally.
- err  output  1  one-cycle pulse on an invalid or dropped command, or on abort.
- vaso  output  1  cup-drop solenoid.
- agua  output  1  water valve.
- motor_cafe  output  1  coffee powder motor.
- motor_te  output  1  tea powder motor.
- dev_moneda  output  1  full-coin return hopper.
- dev_cinco  output  1  5-unit change hopper.

Behaviour:
- Reset:
  - While rst=0, asynchronously force state=S_IDLE, counter=0 and every output to 0.
  - Reset asserted mid-sequence kills all actuators immediately.
- Registered outputs:
  - All outputs are flops decoded from the next state.
  - An actuator is high for exactly its T_* count of cycles.
  - At most one actuator output is high in any cycle.
- States:
  - S_IDLE, S_VASO, S_AGUA, S_POLVO, S_DEVUELVE, S_FIN.
  - The latched command fields are drink (cafe/te), refund type (full/5/none), and the drink flag.
- S_IDLE (ocupado=0):
  - On a clock edge with cmd in {111,110,101}: latch the fields, load counter=T_VASO-1, go to S_VASO. vaso and ocupado go to 1 after that same edge, i.e. 1-cycle latency.
  - cmd=100: latch refund=full, load T_MONEDA-1, go to S_DEVUELVE.
  - cmd in {001,010,011}: stay in S_IDLE, err pulses for 1 cycle.
  - cmd=000: stay in S_IDLE.
- Timed states:
  - Each timed state decrements the counter. On counter=0 it reloads for the next state and advances.
  - Order: S_VASO -> S_AGUA -> S_POLVO.
  - S_POLVO drives motor_cafe or motor_te per the latched drink.
- After S_POLVO:
  - refund=5 (cmd 101): go to S_DEVUELVE with dev_cinco.
  - Otherwise go to S_FIN.
- S_DEVUELVE: drives dev_moneda (refund=full) or dev_cinco (refund=5) for T_MONEDA cycles, then goes to S_FIN.
- S_FIN: listo=1 and ocupado=1 for one cycle, then S_IDLE.
- Total busy length:
  - 111 or 110: T_VASO+T_AGUA+T_POLVO+1.
  - 101: T_VASO+T_AGUA+T_POLVO+T_MONEDA+1.
  - 100: T_MONEDA+1.
- Nonzero cmd while ocupado=1: the command is dropped, err pulses for 1 cycle, and the running sequence is unaffected. This includes a cmd arriving in S_FIN.
- paro=1 in any non-idle state: next edge goes to S_IDLE, all actuators go to 0, err=1 for one cycle, listo stays 0.
- paro=1 in S_IDLE: a nonzero cmd in that cycle is ignored without err.
- paro has priority over cmd and over counter expiry.
- No command queue. A new command is accepted on the first edge with ocupado=0, i.e. the cycle after S_FIN.

Test Plan:
- Reset with defaults, then cmd=111 for one cycle -> vaso high 4 cycles, agua 16, motor_cafe 8, listo pulse; ocupado high 29 cycles; motor_te, dev_* stay 0.
- cmd=101 -> vaso 4, agua 16, motor_te 8, dev_cinco 2, listo; ocupado 31 cycles; dev_moneda 0.
- cmd=100 -> dev_moneda high 2 cycles, listo on 3rd cycle, ocupado 3 cycles; vaso/agua/motors 0.
- cmd=110 then cmd=111 during the agua phase -> err 1-cycle pulse, the tea sequence completes unchanged, no coffee motor; cmd=010 in idle -> err pulse, ocupado stays 0.
- cmd=111, paro=1 on 5th agua cycle -> next cycle all outputs 0, err=1, listo never asserts; the next cmd=110 runs normally.
- rst driven low asynchronously (between clock edges) during motor_cafe -> all outputs 0 immediately without a clock edge; after release the block idles until a new cmd.
